uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter CLK, default 25_000_000: system clock frequency in Hz.
REQ-002 Parameter BPS, default 115200: reset-time baud rate; default divisor DIV0 = CLK/BPS (integer).
REQ-003 Parameter DATA_BIT, default 8: data bits per frame, legal 5..9.
REQ-004 Parameter CHECK_BIT, default "None": parity mode, one of "None", "Odd", "Even", "Mark", "Space".
REQ-005 Parameter STOP_BIT, default 1: stop bits, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16: transmit FIFO entries, power of 2, at least 2; AW = log2(FIFO_DEPTH).
REQ-007 i_clk  in  1  single clock; all logic on its rising edge.
REQ-008 i_reset_n  in  1  synchronous, active-low reset.
REQ-009 i_data  in  DATA_BIT  word to send.
REQ-010 i_valid  in  1  i_data is valid.
REQ-011 o_ready  out  1  FIFO can accept a word.
REQ-012 i_div  in  16  runtime cycles-per-bit divisor; 0 selects DIV0.
REQ-013 i_break  in  1  request a break (line held low).
REQ-014 o_txd  out  1  serial line, idle high.
REQ-015 o_busy  out  1  FSM is not in IDLE, or the FIFO is not empty.
REQ-016 o_level  out  AW+1  current FIFO occupancy.

Function
REQ-017 Write handshake: a word is stored when i_valid && o_ready on a rising edge; o_ready = (o_level != FIFO_DEPTH), combinational from registered state.
REQ-018 FIFO: first-in first-out; pointers wrap modulo FIFO_DEPTH; o_level updates the cycle after a write or pop; a simultaneous write and pop leaves o_level unchanged.
REQ-019 Full FIFO: o_ready=0; i_valid is ignored; stored data is never overwritten.
REQ-020 Divisor: effective divisor D = (i_div==0) ? DIV0 : i_div; D is latched at frame start and is constant for the whole frame; D < 4 is clamped to 4.
REQ-021 Bit timer: a counter restarts at 0 on entering each state; each bit lasts exactly D cycles.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-023 IDLE: o_txd=1. If i_break=1, go to BREAK. Otherwise, if the FIFO is non-empty, pop the head into the shift register, latch D, and go to START the next cycle.
REQ-024 Break has priority over a non-empty FIFO in IDLE; i_break is ignored outside IDLE, so a frame in progress always completes.
REQ-025 START: o_txd=0 for D cycles, then DATA.
REQ-026 DATA: send DATA_BIT bits LSB first, D cycles each. Then go to PARITY if CHECK_BIT != "None", else to STOP.
REQ-027 PARITY: one bit for D cycles. Odd = ~^data, Even = ^data, Mark = 1, Space = 0; parity is computed from the popped word, not the shifted value.
REQ-028 STOP: o_txd=1 for STOP_BIT*D cycles, then IDLE.
REQ-029 BREAK: o_txd=0 while i_break=1, with a minimum of one full frame time (1+DATA_BIT+parity+STOP_BIT bits). After release, o_txd=1 for at least D cycles, then IDLE.
REQ-030 Latency: a word written at edge N into an empty FIFO while idle gives o_txd=0 from edge N+2.
REQ-031 Back-to-back: when the FIFO is non-empty at the end of STOP, the next start bit follows with exactly one idle-high cycle (the IDLE pop cycle).
REQ-032 o_txd is driven directly from a flop (glitch-free).
REQ-033 A write is accepted during transmission and never disturbs the frame in flight.

Reset
REQ-034 With i_reset_n=0 at an edge: FSM=IDLE, FIFO emptied, o_txd=1, o_busy=0, o_level=0, o_ready=1, bit timer=0.
REQ-035 Reset asserted mid-frame aborts the frame immediately; o_txd=1 on the next edge and any FIFO contents are discarded.

Verification
REQ-036 DATA_BIT=8, "None", STOP_BIT=1, i_div=10; write 0xA5 -> o_txd reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles, start bit at edge N+2.
REQ-037 "Odd", i_div=8; write 0x07 -> parity bit = 0 (three ones); with "Even", parity bit = 1; with "Mark", parity bit = 1.
REQ-038 FIFO_DEPTH=4; write 6 words back-to-back while idle -> 5 accepted (one popped immediately), o_ready=0 then; all 5 words sent in order, one idle cycle between frames.
REQ-039 Assert i_break during frame 2 of 3 queued words -> frame 2 completes, break starts; hold i_break for 3 cycles -> o_txd low for one full frame time, then high for D cycles, then frame 3 is sent.
REQ-040 i_div=0, CLK=25e6, BPS=115200 -> 217 cycles per bit; change i_div to 50 mid-frame -> current frame stays at 217, next frame uses 50.
REQ-041 Drop i_reset_n in the 4th data bit -> o_txd=1 on the next edge, o_level=0, o_busy=0; a new write afterwards transmits normally.

Source files
------------

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered UART transmitter with runtime divisor, parity and break
// Ports: i_clk/i_reset_n (sync, active-low); i_data/i_valid/o_ready write side;
//        i_div cycles-per-bit (0 = CLK/BPS); i_break line break request;
//        o_txd serial out (idle high); o_busy; o_level FIFO occupancy.
module uart_tx_buf #(
    parameter int    CLK        = 25_000_000,
    parameter int    BPS        = 115200,
    parameter int    DATA_BIT   = 8,
    parameter string CHECK_BIT  = "None",
    parameter int    STOP_BIT   = 1,
    parameter int    FIFO_DEPTH = 16,
    localparam int   AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic [DATA_BIT-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [15:0]         i_div,
    input  logic                i_break,
    output logic                o_txd,
    output logic                o_busy,
    output logic [AW:0]         o_level
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    localparam logic [15:0] DIV0       = 16'(CLK / BPS);
    localparam int          HAS_PAR    = (CHECK_BIT != "None") ? 1 : 0;
    localparam logic [3:0]  LAST_DATA  = 4'(DATA_BIT - 1);
    localparam logic [3:0]  LAST_STOP  = 4'(STOP_BIT - 1);
    localparam logic [3:0]  FRAME_BITS = 4'(1 + DATA_BIT + HAS_PAR + STOP_BIT);
    localparam logic [AW:0] FULL       = (AW + 1)'(FIFO_DEPTH);
    logic [DATA_BIT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]         level_q, level_d;
    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d, div_q, div_d, div_raw, div_eff;
    logic [3:0]          bit_q, bit_d;
    logic [DATA_BIT-1:0] shr_q, shr_d, head;
    logic                par_q, par_d, brk_hi_q, brk_hi_d, txd_q, txd_d;
    logic                wr, pop, bit_end, head_par, brk_min_done;
    assign o_ready  = level_q != FULL;
    assign o_busy   = state_q != IDLE || level_q != '0;
    assign o_level  = level_q;
    assign o_txd    = txd_q;
    assign wr       = i_valid && o_ready;
    assign head     = mem_q[rd_q];
    assign head_par = (CHECK_BIT == "Odd") ? ~^head : (CHECK_BIT == "Even") ? ^head : (CHECK_BIT == "Mark");
    assign div_raw  = (i_div == 16'd0) ? DIV0 : i_div;
    assign div_eff  = (div_raw < 16'd4) ? 16'd4 : div_raw;
    assign bit_end  = cnt_q == div_q - 16'd1;
    // the minimum break low time is reached on the last cycle of the final frame bit
    assign brk_min_done = bit_q == FRAME_BITS || (bit_end && bit_q == FRAME_BITS - 4'd1);
    always_comb begin
        wr_d    = wr ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        level_d = (wr && !pop) ? level_q + (AW + 1)'(1) : (!wr && pop) ? level_q - (AW + 1)'(1) : level_q;
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        bit_d    = bit_q;
        shr_d    = shr_q;
        par_d    = par_q;
        div_d    = div_q;
        brk_hi_d = brk_hi_q;
        pop      = 1'b0;
        txd_d    = 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                bit_d    = '0;
                brk_hi_d = 1'b0;
                if (i_break) begin
                    state_d = BREAK;
                    div_d   = div_eff;
                end else if (level_q != '0) begin
                    pop     = 1'b1;
                    shr_d   = head;
                    par_d   = head_par;
                    div_d   = div_eff;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shr_q[0];
                if (bit_end) begin
                    cnt_d = '0;
                    shr_d = shr_q >> 1;
                    bit_d = (bit_q == LAST_DATA) ? 4'd0 : bit_q + 4'd1;
                    if (bit_q == LAST_DATA) state_d = (HAS_PAR != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                txd_d = par_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = (bit_q == LAST_STOP) ? 4'd0 : bit_q + 4'd1;
                    state_d = (bit_q == LAST_STOP) ? IDLE : STOP;
                end
            end
            BREAK: begin
                if (!brk_hi_q) begin
                    txd_d = 1'b0;
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q != FRAME_BITS) bit_d = bit_q + 4'd1;
                    end
                    // leave the low phase once a frame time has passed and the request is gone
                    if (brk_min_done && !i_break) begin
                        brk_hi_d = 1'b1;
                        cnt_d    = '0;
                    end
                end else if (bit_end) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset_n && wr) mem_q[wr_q] <= i_data;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            shr_q    <= '0;
            par_q    <= 1'b0;
            brk_hi_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            shr_q    <= shr_d;
            par_q    <= par_d;
            brk_hi_q <= brk_hi_d;
            txd_q    <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: directed self-checking bench for uart_tx_buf
module tb_uart_tx_buf;
    logic        clk, rst_n, valid, brk;
    logic [7:0]  data;
    logic [15:0] div;
    logic        ready, txd, busy;
    logic [2:0]  level;
    logic [2:0]  txdp, rdyp, busyp;
    logic [2:0]  lvlp [3];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  ws [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0]  bw [3] = '{8'hC5, 8'h3A, 8'h96};
    int          lv_exp [6] = '{1, 1, 2, 3, 4, 4};
    int          rd_exp [6] = '{1, 1, 1, 1, 0, 0};
    int          tx_exp [6] = '{1, 1, 0, 0, 0, 0};

    uart_tx_buf #(.CHECK_BIT("None"), .FIFO_DEPTH(4)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(ready),
        .i_div(div), .i_break(brk), .o_txd(txd), .o_busy(busy), .o_level(level));
    uart_tx_buf #(.CHECK_BIT("Odd"), .FIFO_DEPTH(4)) u_odd (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdyp[0]),
        .i_div(div), .i_break(brk), .o_txd(txdp[0]), .o_busy(busyp[0]), .o_level(lvlp[0]));
    uart_tx_buf #(.CHECK_BIT("Even"), .FIFO_DEPTH(4)) u_even (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdyp[1]),
        .i_div(div), .i_break(brk), .o_txd(txdp[1]), .o_busy(busyp[1]), .o_level(lvlp[1]));
    uart_tx_buf #(.CHECK_BIT("Mark"), .FIFO_DEPTH(4)) u_mark (
        .i_clk(clk), .i_reset_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(rdyp[2]),
        .i_div(div), .i_break(brk), .o_txd(txdp[2]), .o_busy(busyp[2]), .o_level(lvlp[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // write one word into an idle, empty DUT; returns just after the pop edge
    task automatic start1(input logic [7:0] w);
        data = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("wr_level", level, 1);
        check("wr_txd0", txd, 1);
        tick();
        check("pop_level", level, 0);
        check("wr_txd1", txd, 1);
    endtask

    // frame cycles c0..c1-1 (cycle 0 = first start-bit cycle); parity DUTs carry pb in bit 9
    task automatic frame(input logic [7:0] w, input int d, input bit par, input logic [2:0] pb,
                         input int c0, input int c1);
        logic [9:0] p;
        p = {1'b1, w, 1'b0};
        for (int j = c0; j < c1; j++) begin
            tick();
            check($sformatf("txd_%02h@%0d", w, j), txd, p[j / d]);
            if (par)
                for (int k = 0; k < 3; k++)
                    check($sformatf("txd_par%0d@%0d", k, j), txdp[k], (j / d == 9) ? pb[k] : p[j / d]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || busyp != 3'b000) && n < 20000) begin
            tick();
            n++;
        end
        check("idle_timeout", {busy, busyp}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; data = '0; div = 16'd10; brk = 1'b0;
        tick();
        tick();
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_ready", ready, 1);
        rst_n = 1'b1;
        tick();
        // basic 8N1 frame, D=10
        start1(8'hA5);
        frame(8'hA5, 10, 1'b0, 3'b000, 0, 100);
        tick();
        check("a5_gap", txd, 1);
        check("a5_busy", busy, 0);
        wait_idle();
        // parity variants, D=8, word 0x07 -> odd 0, even 1, mark 1
        div = 16'd8;
        start1(8'h07);
        frame(8'h07, 8, 1'b1, 3'b110, 0, 80);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("par_stop", txdp, 3'b111);
        end
        wait_idle();
        // divisor below 4 clamps to 4
        div = 16'd2;
        start1(8'hC3);
        frame(8'hC3, 4, 1'b0, 3'b000, 0, 40);
        tick();
        check("clamp_busy", busy, 0);
        wait_idle();
        // FIFO fill: 6 back-to-back writes, 5 accepted
        div = 16'd10;
        for (int k = 0; k < 6; k++) begin
            data = ws[k];
            valid = 1'b1;
            tick();
            check($sformatf("fill_level%0d", k), level, lv_exp[k]);
            check($sformatf("fill_ready%0d", k), ready, rd_exp[k]);
            check($sformatf("fill_txd%0d", k), txd, tx_exp[k]);
        end
        valid = 1'b0;
        frame(ws[0], 10, 1'b0, 3'b000, 4, 100);
        for (int k = 1; k < 5; k++) begin
            tick();
            check("b2b_gap", txd, 1);
            check("b2b_level", level, 4 - k);
            frame(ws[k], 10, 1'b0, 3'b000, 0, 100);
        end
        tick();
        check("fill_end_txd", txd, 1);
        check("fill_end_busy", busy, 0);
        wait_idle();
        // break requested during frame 2 of 3
        for (int k = 0; k < 3; k++) begin
            data = bw[k];
            valid = 1'b1;
            tick();
            check($sformatf("brk_wr_txd%0d", k), txd, (k == 2) ? 0 : 1);
        end
        valid = 1'b0;
        frame(bw[0], 10, 1'b0, 3'b000, 1, 100);
        tick();
        check("brk_gap", txd, 1);
        check("brk_level", level, 1);
        brk = 1'b1;
        frame(bw[1], 10, 1'b0, 3'b000, 0, 100);
        tick();
        check("brk_idle", txd, 1);
        for (int c = 0; c < 100; c++) begin
            tick();
            check($sformatf("brk_low@%0d", c), txd, 0);
            if (c == 2) brk = 1'b0;
        end
        for (int c = 0; c < 11; c++) begin
            tick();
            check($sformatf("brk_high@%0d", c), txd, 1);
        end
        frame(bw[2], 10, 1'b0, 3'b000, 0, 100);
        tick();
        check("brk_end_busy", busy, 0);
        wait_idle();
        // default divisor 217, runtime change only affects the next frame
        div = 16'd0;
        data = 8'h3C;
        valid = 1'b1;
        tick();
        data = 8'hE1;
        tick();
        valid = 1'b0;
        check("div_level", level, 1);
        frame(8'h3C, 217, 1'b0, 3'b000, 0, 1000);
        div = 16'd50;
        frame(8'h3C, 217, 1'b0, 3'b000, 1000, 2170);
        tick();
        check("div_gap", txd, 1);
        frame(8'hE1, 50, 1'b0, 3'b000, 0, 500);
        tick();
        check("div_end_busy", busy, 0);
        wait_idle();
        // reset in the 4th data bit
        div = 16'd10;
        data = 8'h81;
        valid = 1'b1;
        tick();
        data = 8'h7E;
        tick();
        valid = 1'b0;
        frame(8'h81, 10, 1'b0, 3'b000, 0, 45);
        rst_n = 1'b0;
        tick();
        check("mid_rst_txd", txd, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        rst_n = 1'b1;
        start1(8'h5A);
        frame(8'h5A, 10, 1'b0, 3'b000, 0, 100);
        tick();
        check("post_rst_busy", busy, 0);
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
